gray_conv_arbiter: RTL and testbench

- Shares one binary/Gray code converter among NREQ requesters using round-robin arbitration.
- Each requester presents a WIDTH-bit word with a valid/ready handshake.
- The winner's word is converted and held in a one-entry output register, tagged with the requester index, until the downstream consumer accepts it.
- A configuration input selects binary-to-Gray or Gray-to-binary per transaction. The block sits between multiple counter/pointer producers and a single code-conversion consumer, such as async FIFO pointer logic.

---
 rtl/gray_conv_arbiter.sv | 134 +++++++++++++
 tb/tb_gray_conv_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin shared binary/Gray code converter
//
// Purpose: NREQ requesters share one binary<->Gray converter. A round-robin
// arbiter picks one valid requester per cycle whenever the one-entry output
// register is free (or draining). The winner's word is converted and held,
// tagged with its index and the direction used, until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]        per-requester request valid
//   req_data   [NREQ*WIDTH]  requester i in bits [i*WIDTH +: WIDTH]
//   req_ready  [NREQ]        one-hot grant/accept strobe (combinational)
//   cfg_g2b    0 = binary-to-Gray, 1 = Gray-to-binary, sampled at accept
//   out_valid  output register holds a result
//   out_ready  consumer accepts the result
//   out_data   [WIDTH] converted word
//   out_id     [IDW]   index of the requester that produced out_data
//   out_g2b    direction used for out_data
//   busy       out_valid or any req_valid
module gray_conv_arbiter #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  cfg_g2b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_id,
    output logic                  out_g2b,
    output logic                  busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic             can_accept;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] grant_word;
    logic [WIDTH-1:0] conv_word;
    int               scan_idx;

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // The slot can take a new word when empty or when it is being drained
    // this same cycle, giving one word per cycle throughput.
    assign can_accept = (state == EMPTY) | out_ready;
    assign out_valid  = (state == FULL);
    assign busy       = out_valid | (|req_valid);

    // Round-robin scan starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_word  = '0;
        req_ready   = '0;
        scan_idx    = 0;
        if (can_accept) begin
            for (int off = 0; off < NREQ; off++) begin
                scan_idx = int'(rr_ptr) + off;
                if (scan_idx >= NREQ) begin
                    scan_idx = scan_idx - NREQ;
                end
                if (!grant_found && req_valid[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = IDW'(scan_idx);
                    grant_word  = req_data[scan_idx*WIDTH +: WIDTH];
                end
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign conv_word = cfg_g2b ? gray_to_bin(grant_word) : bin_to_gray(grant_word);

    always_comb begin
        state_nxt = state;
        if (grant_found) begin
            state_nxt = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Result register and pointer only move on an accept; a plain drain
    // leaves out_data/out_id/out_g2b holding their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_id   <= '0;
            out_g2b  <= 1'b0;
            rr_ptr   <= '0;
        end else if (grant_found) begin
            out_data <= conv_word;
            out_id   <= grant_idx;
            out_g2b  <= cfg_g2b;
            rr_ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - directed self-checking bench for gray_conv_arbiter
module tb_gray_conv_arbiter;

    localparam int WIDTH = 3;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  cfg_g2b;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_g2b;
    logic                  busy;

    int n_tests;
    int n_fail;

    // Gray code of 0..7, written out by hand.
    logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                 3'b110, 3'b111, 3'b101, 3'b100};

    gray_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cfg_g2b   (cfg_g2b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_g2b   (out_g2b),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] g;
        logic [3:0] exp_rr;
        int         seq [8];
        n_tests   = 0;
        n_fail    = 0;
        req_valid = '0;
        req_data  = '0;
        cfg_g2b   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data),  0);
        check("rst_out_id",    32'(out_id),    0);
        check("rst_out_g2b",   32'(out_g2b),   0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy",      32'(busy),      0);
        step();
        rst_n = 1'b1;

        // Single request from requester 2, binary 101 -> Gray 111.
        req_valid = 4'b0100;
        req_data  = {3'b000, 3'b101, 3'b000, 3'b000};
        #1;
        check("t1_req_ready", 32'(req_ready), 32'b0100);
        check("t1_busy", 32'(busy), 1);
        step();
        req_valid = '0;
        #1;
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_out_data",  32'(out_data),  32'b111);
        check("t1_out_id",    32'(out_id),    2);
        check("t1_out_g2b",   32'(out_g2b),   0);

        // Requester 0, Gray 111 -> binary 101, drain and accept together.
        out_ready = 1'b1;
        cfg_g2b   = 1'b1;
        req_valid = 4'b0001;
        req_data  = {9'b0, 3'b111};
        #1;
        check("t2_req_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        #1;
        check("t2_out_data", 32'(out_data), 32'b101);
        check("t2_out_id",   32'(out_id),   0);
        check("t2_out_g2b",  32'(out_g2b),  1);

        // Sweep all codes both directions, check round trip.
        for (int v = 0; v < 8; v++) begin
            cfg_g2b   = 1'b0;
            req_valid = 4'b0001;
            req_data  = {9'b0, 3'(v)};
            step();
            check($sformatf("b2g_%0d", v), 32'(out_data), 32'(gray_tab[v]));
            g         = out_data;
            cfg_g2b   = 1'b1;
            req_data  = {9'b0, g};
            step();
            check($sformatf("g2b_tab_%0d", v), 32'(out_data), 32'(v));
            req_valid = '0;
        end
        step();
        check("drain_empty", 32'(out_valid), 0);
        check("drain_hold",  32'(out_data),  7);

        // Fairness: all valid, out_ready=1, from rr_ptr=0.
        do_reset();
        cfg_g2b   = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        req_data  = {3'd7, 3'd6, 3'd5, 3'd4};
        seq       = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_rr = 4'b0001 << seq[i];
            check($sformatf("fair_rdy_%0d", i), 32'(req_ready), 32'(exp_rr));
            step();
            check($sformatf("fair_id_%0d", i), 32'(out_id), 32'(seq[i]));
            check($sformatf("fair_vld_%0d", i), 32'(out_valid), 1);
        end
        // Last result: requester 3, word 7 -> Gray 100.
        check("fair_last_data", 32'(out_data), 32'b100);

        // Backpressure with requesters 1 and 3 valid.
        out_ready = 1'b0;
        req_valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_rdy_%0d", i), 32'(req_ready), 0);
            step();
            check($sformatf("bp_data_%0d", i), 32'(out_data), 32'b100);
            check($sformatf("bp_id_%0d", i), 32'(out_id), 3);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy1", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b1000;
        check("bp_rel_id1", 32'(out_id), 1);
        #1;
        check("bp_rel_rdy3", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        check("bp_rel_id3", 32'(out_id), 3);

        // Wrap/skip: get rr_ptr to 3 via a grant to 2.
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0101;
        #1;
        check("wrap_rdy0", 32'(req_ready), 32'b0001);
        step();
        check("wrap_id0", 32'(out_id), 0);
        req_valid = 4'b0100;
        #1;
        check("wrap_rdy2", 32'(req_ready), 32'b0100);
        step();
        check("wrap_id2", 32'(out_id), 2);
        req_valid = 4'b1111;
        #1;
        check("wrap_ptr3", 32'(req_ready), 32'b1000);

        // Async reset while FULL and backpressured.
        req_valid = '0;
        out_ready = 1'b0;
        #1;
        check("ar_pre_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 0);
        check("ar_out_id",    32'(out_id),    0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("ar_first_rdy", 32'(req_ready), 32'b0001);
        step();
        check("ar_first_id", 32'(out_id), 0);
        req_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
